// File: rtl/regfile_dump.sv
// Walks the register file and streams every word out as bytes, LSB first.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum byte after the data.
module regfile_dump #(
  parameter int DataWidth    = 32,
  parameter int Registers    = 32,
  parameter int AddrRegWidth = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [AddrRegWidth-1:0] rd_addr,
  input  logic [DataWidth-1:0]    rd_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int NB = DataWidth / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_CSUM,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [AddrRegWidth-1:0] r_addr;
  logic [IW-1:0]           r_idx;
  logic [DataWidth-1:0]    r_word;
  logic [7:0]              w_byte;
  logic                    w_hs;
  logic                    w_last_byte;
  logic                    w_last_reg;
`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0]              r_csum;
`endif

  assign w_byte      = r_word[{r_idx, 3'b000} +: 8];
  assign w_hs        = tx_valid & tx_ready;
  assign w_last_byte = (r_idx == IW'(NB - 1));
  assign w_last_reg  = (r_addr == AddrRegWidth'(Registers - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_hs && w_last_byte) begin
          if (!w_last_reg) begin
            w_state_nxt = S_LOAD;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            w_state_nxt = S_CSUM;
`else
            w_state_nxt = S_DONE;
`endif
          end
        end
      end
      S_CSUM: if (w_hs) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address returns to 0 as soon as the last word has gone out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_idx  <= '0;
      r_word <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr <= '0;
            r_idx  <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            r_csum <= '0;
`endif
          end
        end
        S_LOAD: r_word <= rd_data;
        S_SEND: begin
          if (w_hs) begin
`ifdef REGDUMP_CHECKSUM_EN
            r_csum <= r_csum ^ w_byte;
`endif
            if (w_last_byte) begin
              r_idx  <= '0;
              r_addr <= w_last_reg ? '0
                      : r_addr + AddrRegWidth'(1);
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
    rd_addr  = r_addr;
    unique case (r_state)
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = w_byte;
      end
      S_CSUM: begin
        tx_valid = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        tx_data  = r_csum;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: byte-stream model, stall and reset checks.
// Honours REGDUMP_CHECKSUM_EN the same way as the design.
module tb_regfile_dump;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NB = DW / 8;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int NBYTES = NR * NB + 1;
`else
  localparam int NBYTES = NR * NB;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [NR];
  logic [7:0]    exp_q [$];
  logic [7:0]    cap [$];
  int            tests = 0;
  int            fails = 0;
  int            rmode = 0;
  int            ndone = 0;
  logic          prev_stall = 1'b0;
  logic [7:0]    prev_data = 8'h00;

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  regfile_dump #(
    .DataWidth   (DW),
    .Registers   (NR),
    .AddrRegWidth(AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected stream: every register, LSB byte first, then optional XOR.
  task automatic build_model();
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    for (int k = 0; k < NR; k++) begin
      for (int b = 0; b < NB; b++) begin
        exp_q.push_back(regs[k][8*b +: 8]);
        x = x ^ regs[k][8*b +: 8];
      end
    end
`ifdef REGDUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic load_pattern();
    for (int k = 0; k < NR; k++) regs[k] = k * 32'h01010101;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic kick();
    build_model();
    cap.delete();
    ndone = 0;
    pulse_start();
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000 && ndone == 0; i++) begin
      @(negedge clk); #1;
    end
    if (ndone == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done, expected done", name);
    end
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_ndone"}, ndone, 1);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_addr0"}, rd_addr, 0);
    chk({name, "_count"}, cap.size(), NBYTES);
    chk({name, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, prev_data);
      end
      if (!busy) chk("idle_valid", tx_valid, 0);
      if (done) begin
        ndone++;
        chk("done_valid", tx_valid, 0);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_byte: got %0h, expected none", tx_data);
        end else begin
          chk("byte", tx_data, exp_q.pop_front());
        end
        cap.push_back(tx_data);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    load_pattern();
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rd_addr, 0);
    #20;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);

    rmode = 0;
    kick();
    wait_done("t1");
    chk("t1_b0", cap[0], 8'h00);
    chk("t1_b3", cap[3], 8'h00);
    chk("t1_b4", cap[4], 8'h01);
    chk("t1_b127", cap[127], 8'h1F);

    regs[1] = 32'h12345678;
    rmode = 1;
    kick();
    wait_done("t2");
    chk("t2_b4", cap[4], 8'h78);
    chk("t2_b5", cap[5], 8'h56);
    chk("t2_b6", cap[6], 8'h34);
    chk("t2_b7", cap[7], 8'h12);

    for (int k = 0; k < NR; k++) regs[k] = '0;
    regs[1] = 32'h000000FF;
    rmode = 0;
    kick();
    wait_done("t3");
`ifdef REGDUMP_CHECKSUM_EN
    chk("t3_csum", cap[128], 8'hFF);
`endif
    chk("t3_b4", cap[4], 8'hFF);

    load_pattern();
    rmode = 1;
    kick();
    for (int i = 0; i < 2000 && cap.size() < 10; i++) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 2000 && cap.size() < 60; i++) @(negedge clk);
    pulse_start();
    wait_done("t4");

    rmode = 0;
    kick();
    for (int i = 0; i < 2000 && !(rd_addr == 7 && tx_valid); i++)
      @(negedge clk);
    rmode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("t5_stall_addr", rd_addr, 7);
    chk("t5_stalled", tx_valid && !tx_ready, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_valid", tx_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_addr", rd_addr, 0);
    exp_q.delete();
    cap.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rmode = 0;
    repeat (20) @(negedge clk);
    chk("t5_quiet", cap.size(), 0);
    chk("t5_quiet_busy", busy, 0);
    kick();
    wait_done("t5");
    chk("t5_b0", cap[0], 8'h00);
    chk("t5_b28", cap[28], 8'h07);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter DataWidth, default 32, width of one register word (multiple of 8).
REQ-002 SHALL have parameter Registers, default 32, number of registers walked per dump.
REQ-003 SHALL have parameter AddrRegWidth, default 5, register address width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  dump request, sampled in IDLE only.
REQ-007 SHALL have port rd_addr  output  AddrRegWidth  register-file read address (to rs1/rs2 port).
REQ-008 SHALL have port rd_data  input  DataWidth  combinational read data for rd_addr.
REQ-009 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid.
REQ-011 SHALL have port tx_ready  input  1  transmitter accepts byte this cycle.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at dump end.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SEND, CSUM, DONE.
REQ-015 IDLE: start=1 -> rd_addr<=0, byte index<=0, LOAD; start=0 -> stay.
REQ-016 LOAD: capture rd_data into word register, go SEND (one cycle; no tx_valid).
REQ-017 SEND: tx_valid=1, tx_data = word byte [index], byte 0 = bits 7:0 first (little-endian).
REQ-018 Byte handshake completes only on cycle with tx_valid=1 and tx_ready=1.
REQ-019 While tx_valid=1 and tx_ready=0, tx_data SHALL stay stable and tx_valid SHALL stay high.
REQ-020 On handshake of a non-last byte: index+1, stay SEND.
REQ-021 On last byte (index DataWidth/8-1) with rd_addr < Registers-1: rd_addr+1, index<=0, LOAD.
REQ-022 On last byte with rd_addr = Registers-1: CSUM if REGDUMP_CHECKSUM_EN defined, else DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; rd_addr SHALL then read 0.
REQ-024 start while busy SHALL be ignored (no restart, no queueing).
REQ-025 Register r0 SHALL be sent like any other register (value as read).
REQ-026 Dump is not atomic: each word reflects rd_data in its LOAD cycle.
REQ-027 Byte count per dump = Registers*DataWidth/8 (128 at defaults), plus 1 with checksum.
REQ-028 tx_valid SHALL never be high in IDLE, LOAD or DONE.

Reset
REQ-029 rst=0 SHALL immediately force IDLE regardless of clock, including mid-byte stalls.
REQ-030 Reset values: rd_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, index=0, word=0, checksum=0.
REQ-031 After rst returns high, no byte SHALL be emitted until a new start.

Configuration
REQ-032 Macro REGDUMP_CHECKSUM_EN SHALL gate a trailing checksum byte.
REQ-033 Defined: running XOR of every data byte sent, cleared on start; CSUM state drives it with tx_valid=1 under REQ-018/019, then DONE.
REQ-034 Undefined: no checksum register, CSUM unreachable, last data byte goes to DONE.

Verification
REQ-035 r[k]=k*0x01010101, start pulse, tx_ready=1 always -> bytes 00 00 00 00 01 01 01 01 ... 1F 1F 1F 1F, 128 bytes, done once, busy low after.
REQ-036 r1=0x12345678, tx_ready toggling 1/0 -> register 1 bytes 78 56 34 12, each held stable across stalls, no duplicates or drops.
REQ-037 With REGDUMP_CHECKSUM_EN, r1=0x000000FF, others 0 -> 129th byte = 0xFF; without macro exactly 128 bytes.
REQ-038 start pulses asserted at byte 10 and byte 60 -> still exactly one dump, one done pulse.
REQ-039 rst low during stalled SEND of register 7 -> tx_valid=0, busy=0, rd_addr=0 asynchronously; new start dumps from register 0.
REQ-040 tx_ready=1 in IDLE/LOAD cycles -> no handshake counted, byte sequence unchanged.
